mna_response_transmitter_vc: RTL

//  Master-NA response path: reassembles 2-flit NoC response packets (head+tail) arriving on
//  NUM_VC virtual channels and drives AXI4-Lite B and R channels with full valid/ready handshake.
//  Per-type response FIFOs decouple NoC flit arrival from AXI back-pressure; per-VC on/off and

---
 rtl/mna_response_transmitter_vc.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mna_response_transmitter_vc.sv
`default_nettype none
// ============================================================================
// Module      : mna_response_transmitter_vc
// Description : Master-NA response path. Reassembles two-flit NoC response
//               packets (head + tail) arriving on NUM_VC virtual channels and
//               presents them on AXI4-Lite B and R channels. Separate B and R
//               response FIFOs absorb AXI back-pressure. Per-VC allocatable
//               and on/off flags give the router credit-style flow control.
// Ports       : clk, rst_n (synchronous, active low)
//               is_valid, flit[DATA_WIDTH+1:0], flit_vc[VC_W-1:0] - NoC input
//               is_allocatable[NUM_VC], is_on_off[NUM_VC]     - VC flow control
//               bresp, bvalid, bready                         - AXI B channel
//               rdata, rresp, rvalid, rready                  - AXI R channel
//               proto_err                                     - sticky error flag
//               err_cnt[7:0] (only with MNA_RESP_ERR_CNT_EN)  - error event count
// Options     : `define MNA_RESP_ERR_CNT_EN adds the saturating err_cnt port.
// Flit format : [DATA_WIDTH+1] head, [DATA_WIDTH] write(1)/read(0),
//               head [1:0] resp, tail [DATA_WIDTH-1:0] read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mna_response_transmitter_vc #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_VC     = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  is_valid,
    input  logic [DATA_WIDTH+1:0] flit,
    input  logic [VC_W-1:0]       flit_vc,
    output logic [NUM_VC-1:0]     is_allocatable,
    output logic [NUM_VC-1:0]     is_on_off,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  proto_err
`ifdef MNA_RESP_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int FLIT_W = DATA_WIDTH + 2;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PEND_W = $clog2(NUM_VC + 1);
    // Comparison width large enough for both FIFO free space and pending count
    localparam int CMP_W  = ((CNT_W > PEND_W) ? CNT_W : PEND_W) + 1;
    localparam int R_W    = DATA_WIDTH + 2;

    typedef enum logic [0:0] {
        VC_IDLE      = 1'b0,
        VC_HEAD_HELD = 1'b1
    } vc_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    vc_state_e         vc_state_q [NUM_VC];
    vc_state_e         vc_state_d [NUM_VC];
    logic [NUM_VC-1:0] hdr_wr_q, hdr_wr_d;
    logic [1:0]        hdr_resp_q [NUM_VC];
    logic [1:0]        hdr_resp_d [NUM_VC];

    logic [1:0]        b_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  b_wr_ptr_q, b_wr_ptr_d;
    logic [PTR_W-1:0]  b_rd_ptr_q, b_rd_ptr_d;
    logic [CNT_W-1:0]  b_cnt_q, b_cnt_d;

    logic [R_W-1:0]    r_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr_q, r_wr_ptr_d;
    logic [PTR_W-1:0]  r_rd_ptr_q, r_rd_ptr_d;
    logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;

    logic              proto_err_q, proto_err_d;
`ifdef MNA_RESP_ERR_CNT_EN
    logic [7:0]        err_cnt_q, err_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Flit decode
    // ------------------------------------------------------------------
    logic                  w_head;
    logic                  w_wr_bit;
    logic [1:0]            w_resp;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_vc_ok;

    assign w_head   = flit[FLIT_W-1];
    assign w_wr_bit = flit[DATA_WIDTH];
    assign w_resp   = flit[1:0];
    assign w_data   = flit[DATA_WIDTH-1:0];
    // Guards non-power-of-two NUM_VC against a VC index with no channel
    assign w_vc_ok  = (32'(flit_vc) < 32'(NUM_VC));

    // ------------------------------------------------------------------
    // AXI side: FIFO head drives the channel; pop on handshake
    // ------------------------------------------------------------------
    logic w_b_pop, w_r_pop, w_b_full, w_r_full;

    assign bvalid   = (b_cnt_q != '0);
    assign rvalid   = (r_cnt_q != '0);
    assign w_b_pop  = bvalid && bready;
    assign w_r_pop  = rvalid && rready;
    assign w_b_full = (b_cnt_q == CNT_W'(FIFO_DEPTH));
    assign w_r_full = (r_cnt_q == CNT_W'(FIFO_DEPTH));

    // Stale memory contents are masked so an empty channel shows zeros
    assign bresp = bvalid ? b_mem_q[b_rd_ptr_q] : 2'b00;
    assign rresp = rvalid ? r_mem_q[r_rd_ptr_q][R_W-1 -: 2] : 2'b00;
    assign rdata = rvalid ? r_mem_q[r_rd_ptr_q][DATA_WIDTH-1:0] : '0;

    // ------------------------------------------------------------------
    // Per-VC packet reassembly
    // ------------------------------------------------------------------
    logic           w_b_push, w_r_push, w_err_event;
    logic [1:0]     w_b_push_data;
    logic [R_W-1:0] w_r_push_data;

    always_comb begin
        vc_state_d    = vc_state_q;
        hdr_wr_d      = hdr_wr_q;
        hdr_resp_d    = hdr_resp_q;
        w_b_push      = 1'b0;
        w_r_push      = 1'b0;
        w_b_push_data = 2'b00;
        w_r_push_data = '0;
        w_err_event   = 1'b0;

        if (is_valid && !w_vc_ok) begin
            w_err_event = 1'b1;
        end

        for (int v = 0; v < NUM_VC; v++) begin
            if (is_valid && w_vc_ok && (flit_vc == VC_W'(v))) begin
                if (w_head) begin
                    // A second head overwrites the held one but is flagged
                    if (vc_state_q[v] == VC_HEAD_HELD) begin
                        w_err_event = 1'b1;
                    end
                    vc_state_d[v] = VC_HEAD_HELD;
                    hdr_wr_d[v]   = w_wr_bit;
                    hdr_resp_d[v] = w_resp;
                end else if (vc_state_q[v] == VC_IDLE) begin
                    w_err_event = 1'b1;
                end else begin
                    // Tail completes the packet; the VC frees even when the
                    // response has to be dropped
                    vc_state_d[v] = VC_IDLE;
                    if (hdr_wr_q[v]) begin
                        if (!w_b_full || w_b_pop) begin
                            w_b_push      = 1'b1;
                            w_b_push_data = hdr_resp_q[v];
                        end else begin
                            w_err_event = 1'b1;
                        end
                    end else begin
                        if (!w_r_full || w_r_pop) begin
                            w_r_push      = 1'b1;
                            w_r_push_data = {hdr_resp_q[v], w_data};
                        end else begin
                            w_err_event = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointer and count update
    // ------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        b_wr_ptr_d = w_b_push ? ptr_inc(b_wr_ptr_q) : b_wr_ptr_q;
        b_rd_ptr_d = w_b_pop  ? ptr_inc(b_rd_ptr_q) : b_rd_ptr_q;
        r_wr_ptr_d = w_r_push ? ptr_inc(r_wr_ptr_q) : r_wr_ptr_q;
        r_rd_ptr_d = w_r_pop  ? ptr_inc(r_rd_ptr_q) : r_rd_ptr_q;

        case ({w_b_push, w_b_pop})
            2'b10:   b_cnt_d = b_cnt_q + 1'b1;
            2'b01:   b_cnt_d = b_cnt_q - 1'b1;
            default: b_cnt_d = b_cnt_q;
        endcase
        case ({w_r_push, w_r_pop})
            2'b10:   r_cnt_d = r_cnt_q + 1'b1;
            2'b01:   r_cnt_d = r_cnt_q - 1'b1;
            default: r_cnt_d = r_cnt_q;
        endcase

        proto_err_d = proto_err_q | w_err_event;
`ifdef MNA_RESP_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
        if (w_err_event && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Flow control flags
    // ------------------------------------------------------------------
    logic [CMP_W-1:0] w_pending, w_b_free, w_r_free;

    always_comb begin
        w_pending = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            is_allocatable[v] = (vc_state_q[v] == VC_IDLE);
            if (vc_state_q[v] == VC_HEAD_HELD) begin
                w_pending = w_pending + CMP_W'(1);
            end
        end
        w_b_free = CMP_W'(FIFO_DEPTH) - CMP_W'(b_cnt_q);
        w_r_free = CMP_W'(FIFO_DEPTH) - CMP_W'(r_cnt_q);
        // Strictly greater: every held header still has a slot reserved,
        // plus one for a new head the router may send
        is_on_off = ((w_b_free > w_pending) && (w_r_free > w_pending)) ?
                    {NUM_VC{1'b1}} : {NUM_VC{1'b0}};
    end

    assign proto_err = proto_err_q;
`ifdef MNA_RESP_ERR_CNT_EN
    assign err_cnt = err_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                vc_state_q[v] <= VC_IDLE;
                hdr_resp_q[v] <= 2'b00;
            end
            hdr_wr_q    <= '0;
            b_wr_ptr_q  <= '0;
            b_rd_ptr_q  <= '0;
            b_cnt_q     <= '0;
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_cnt_q     <= '0;
            proto_err_q <= 1'b0;
`ifdef MNA_RESP_ERR_CNT_EN
            err_cnt_q   <= 8'd0;
`endif
        end else begin
            vc_state_q  <= vc_state_d;
            hdr_wr_q    <= hdr_wr_d;
            hdr_resp_q  <= hdr_resp_d;
            b_wr_ptr_q  <= b_wr_ptr_d;
            b_rd_ptr_q  <= b_rd_ptr_d;
            b_cnt_q     <= b_cnt_d;
            r_wr_ptr_q  <= r_wr_ptr_d;
            r_rd_ptr_q  <= r_rd_ptr_d;
            r_cnt_q     <= r_cnt_d;
            proto_err_q <= proto_err_d;
`ifdef MNA_RESP_ERR_CNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    // FIFO storage needs no reset: entries are only visible once counted
    always_ff @(posedge clk) begin
        if (rst_n && w_b_push) begin
            b_mem_q[b_wr_ptr_q] <= w_b_push_data;
        end
        if (rst_n && w_r_push) begin
            r_mem_q[r_wr_ptr_q] <= w_r_push_data;
        end
    end

endmodule
`default_nettype wire
